// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the write-side
// FIFO scheduler and its round-robin picker.
package fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_MAX_BURST  = 8;
  localparam int DEF_ID_WIDTH   = 2;

  localparam int MAX_REQ      = 8;
  localparam int MAX_ID_WIDTH = 3;

  // OR of set-bit positions; exact for one-hot input
  function automatic logic [MAX_ID_WIDTH-1:0]
    onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_ID_WIDTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) begin
        idx = idx | MAX_ID_WIDTH'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester lanes, FIFO write port and status
// of the write-side scheduler.
interface fifo_wr_arbiter_if
  import fifo_wr_arb_pkg::*;
#(
  parameter int data_width = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int id_width   = DEF_ID_WIDTH
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*data_width-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ack;

  logic                  fifo_wr_en;
  logic [data_width-1:0] fifo_data;
  logic                  fifo_full;
  logic                  fifo_almost_full;

  logic                busy;
  logic [id_width-1:0] owner;

  modport master (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ack,
    output fifo_wr_en,
    output fifo_data,
    input  fifo_full,
    input  fifo_almost_full,
    output busy,
    output owner
  );

  modport slave (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ack,
    input  fifo_wr_en,
    input  fifo_data,
    output fifo_full,
    output fifo_almost_full,
    input  busy,
    input  owner
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request
// after rr_ptr, wrapping modulo NUM_REQ.
module rr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int id_width = DEF_ID_WIDTH
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [id_width-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [id_width-1:0] grant_idx
);

  logic [MAX_REQ-1:0]  grant_pad;
  logic [id_width-1:0] idx;
  logic                found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = id_width'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    grant_pad = '0;
    grant_pad[NUM_REQ-1:0] = grant;
  end

  assign grant_idx = id_width'(onehot_to_idx(grant_pad));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the async FIFO write port between NUM_REQ
// requesters in bounded round-robin bursts.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int data_width = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int id_width   = DEF_ID_WIDTH
) (
  input logic               wr_clk,
  input logic               rst,
  fifo_wr_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MAX_BURST - 1);
  localparam logic [id_width-1:0] PTR_RST =
    id_width'(NUM_REQ - 1);

  arb_state_e state;
  arb_state_e state_nxt;

  logic [CNT_W-1:0]    beat_cnt;
  logic [id_width-1:0] owner_q;
  logic [id_width-1:0] rr_ptr;
  logic [id_width-1:0] grant_idx;
  logic [NUM_REQ-1:0]  grant;

  logic start;
  logic ack;
  logic done;
  logic own_valid;
  logic own_last;

  logic [data_width-1:0] own_data;
  logic                  wr_en_q;
  logic [data_width-1:0] data_q;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .id_width (id_width)
  ) u_rr (
    .req       (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign own_valid = bus.req_valid[owner_q];
  assign own_last  = bus.req_last[owner_q];
  assign own_data  =
    bus.req_data[owner_q*data_width +: data_width];

  always_comb begin
    state_nxt   = state;
    start       = 1'b0;
    ack         = 1'b0;
    done        = 1'b0;
    bus.req_ack = '0;
    unique case (state)
      IDLE: begin
        start = (|grant) & ~bus.fifo_almost_full;
        if (start) begin
          state_nxt = BURST;
        end
      end
      BURST: begin
        ack  = own_valid & ~bus.fifo_full;
        // last beat or forced preemption at MAX_BURST
        done = ack &
          (own_last | (beat_cnt == CNT_LAST));
        bus.req_ack[owner_q] = ack;
        if (done) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      owner_q  <= '0;
      rr_ptr   <= PTR_RST;
    end else if (start) begin
      beat_cnt <= '0;
      owner_q  <= grant_idx;
      rr_ptr   <= grant_idx;
    end else if (ack) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      wr_en_q <= 1'b0;
      data_q  <= '0;
    end else begin
      wr_en_q <= ack;
      if (ack) begin
        data_q <= own_data;
      end
    end
  end

  assign bus.fifo_wr_en = wr_en_q;
  assign bus.fifo_data  = data_q;
  assign bus.busy       = (state == BURST);
  assign bus.owner      = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Random lane traffic against a transaction-level
// model of the write-side scheduler.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 8;
  localparam int IW = 2;

  logic wr_clk = 1'b0;
  logic rst    = 1'b1;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter_if #(
    .data_width (DW),
    .NUM_REQ    (NR),
    .id_width   (IW)
  ) bus ();

  fifo_wr_arbiter #(
    .data_width (DW),
    .NUM_REQ    (NR),
    .MAX_BURST  (MB),
    .id_width   (IW)
  ) dut (
    .wr_clk (wr_clk),
    .rst    (rst),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // lane queues: bit 8 = last, bits 7:0 = {lane, seq}
  logic [8:0] lane_q [NR][$];
  int gen_seq [NR];
  int exp_seq [NR];

  int p_on    = 100;
  int p_full  = 0;
  int p_afull = 0;
  int blen    = 2;
  logic [NR-1:0] en_mask = '1;

  bit         m_busy;
  int         m_own;
  int         m_rr;
  int         m_cnt;
  bit         m_wr;
  logic [7:0] m_data;
  int         grants[$];
  int         grant_beats[$];

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic int qat(int q[$], int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic int rr_pick(logic [NR-1:0] v,
                                 int last);
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic refill(int i);
    int n;
    bit nolast;
    logic [7:0] d;
    nolast = (blen < 0);
    if (nolast) n = 4;
    else if (blen > 0) n = blen;
    else n = int'($urandom_range(12, 1));
    for (int b = 0; b < n; b++) begin
      d = {2'(i), 6'(gen_seq[i])};
      lane_q[i].push_back({(!nolast && b == n - 1), d});
      gen_seq[i]++;
    end
  endtask

  task automatic drive();
    logic [NR-1:0]    v;
    logic [NR-1:0]    l;
    logic [NR*DW-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < NR; i++) begin
      if (lane_q[i].size() == 0) refill(i);
      d[i*DW +: DW] = lane_q[i][0][7:0];
      l[i] = lane_q[i][0][8];
      v[i] = en_mask[i] &&
             ($urandom_range(99) < p_on);
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.fifo_full = ($urandom_range(99) < p_full);
    bus.fifo_almost_full =
      ($urandom_range(99) < p_afull);
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_own  = 0;
    m_rr   = NR - 1;
    m_cnt  = 0;
    m_wr   = 1'b0;
    m_data = '0;
    grants.delete();
    grant_beats.delete();
  endtask

  task automatic restart();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin
      lane_q[i].delete();
      exp_seq[i] = gen_seq[i];
    end
    @(posedge wr_clk);
    #1 rst = 1'b0;
    model_reset();
    drive();
  endtask

  task automatic cycle();
    logic [NR-1:0] ea;
    int lane;
    int seq;
    @(negedge wr_clk);
    ea = '0;
    if (m_busy && bus.req_valid[m_own] &&
        !bus.fifo_full) ea[m_own] = 1'b1;
    check("ack", bus.req_ack, ea);
    check("busy", bus.busy, m_busy);
    check("owner", bus.owner, m_own);
    check("wr_en", bus.fifo_wr_en, m_wr);
    if (m_wr) check("data", bus.fifo_data, m_data);
    if (bus.fifo_wr_en) begin
      lane = int'(bus.fifo_data[7:6]);
      seq  = int'(bus.fifo_data[5:0]);
      check("order", seq, exp_seq[lane] % 64);
      exp_seq[lane]++;
    end
    @(posedge wr_clk);
    m_wr = (ea != '0);
    if (m_wr) begin
      m_data = lane_q[m_own][0][7:0];
      m_cnt++;
      if (lane_q[m_own][0][8] || m_cnt == MB) begin
        m_busy = 1'b0;
        grant_beats.push_back(m_cnt);
      end
      void'(lane_q[m_own].pop_front());
    end else if (!m_busy) begin
      if (bus.req_valid != '0 &&
          !bus.fifo_almost_full) begin
        m_own  = rr_pick(bus.req_valid, m_rr);
        m_rr   = m_own;
        m_busy = 1'b1;
        m_cnt  = 0;
        grants.push_back(m_own);
      end
    end
    #1 drive();
  endtask

  task automatic run(int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  task automatic wait_beat(int own, int cnt,
                           string tag);
    int k;
    k = 0;
    while (k < 60 &&
           !(m_busy && m_own == own && m_cnt == cnt))
    begin
      cycle();
      k++;
    end
    check(tag, k < 60, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      gen_seq[i] = 0;
      exp_seq[i] = 0;
    end
    bus.req_valid        = '1;
    bus.req_last         = '0;
    bus.req_data         = '0;
    bus.fifo_full        = 1'b0;
    bus.fifo_almost_full = 1'b0;

    @(negedge wr_clk);
    check("rst_wr_en", bus.fifo_wr_en, 1'b0);
    check("rst_data", bus.fifo_data, 8'h00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_owner", bus.owner, 2'd0);
    check("rst_ack", bus.req_ack, 4'h0);

    // fairness: all lanes, 2-beat bursts
    en_mask = 4'hF;
    blen    = 2;
    restart();
    run(20);
    check("fair_g0", qat(grants, 0), 0);
    check("fair_g1", qat(grants, 1), 1);
    check("fair_g2", qat(grants, 2), 2);
    check("fair_g3", qat(grants, 3), 3);
    check("fair_g4", qat(grants, 4), 0);
    for (int g = 0; g < 4; g++)
      check("fair_beats", qat(grant_beats, g), 2);

    // preemption: lane 1 alone, never last
    en_mask = 4'b0010;
    blen    = -1;
    restart();
    run(30);
    check("pre_b0", qat(grant_beats, 0), MB);
    check("pre_b1", qat(grant_beats, 1), MB);
    check("pre_g1", qat(grants, 1), 1);

    // reset during beat 3 of lane 2
    en_mask = 4'b0100;
    restart();
    wait_beat(2, 2, "rst_reach");
    #2 rst = 1'b1;
    #1;
    check("rmid_wr_en", bus.fifo_wr_en, 1'b0);
    check("rmid_busy", bus.busy, 1'b0);
    check("rmid_owner", bus.owner, 2'd0);
    check("rmid_ack", bus.req_ack, 4'h0);
    en_mask = 4'b0101;
    blen    = 2;
    restart();
    run(4);
    check("rmid_first", qat(grants, 0), 0);

    // throttle on almost_full in IDLE
    en_mask = 4'hF;
    blen    = 0;
    p_afull = 100;
    restart();
    run(10);
    check("thr_hold", grants.size(), 0);
    p_afull = 0;
    bus.fifo_almost_full = 1'b0;
    cycle();
    check("thr_grant", grants.size(), 1);
    run(4);

    // full for 3 cycles at beat 4
    en_mask = 4'b0001;
    blen    = -1;
    restart();
    wait_beat(0, 3, "full_reach");
    p_full = 100;
    bus.fifo_full = 1'b1;
    run(2);
    p_full = 0;
    run(12);
    check("full_beats", qat(grant_beats, 0), MB);

    // owner bubble while others request
    en_mask = 4'b0100;
    restart();
    wait_beat(2, 2, "bub_reach");
    en_mask = 4'b1011;
    drive();
    run(5);
    check("bub_busy", bus.busy, 1'b1);
    check("bub_owner", bus.owner, 2'd2);
    en_mask = 4'hF;
    run(20);

    // random mix
    blen    = 0;
    p_on    = 70;
    p_full  = 20;
    p_afull = 15;
    restart();
    run(3000);
    p_on    = 35;
    p_full  = 40;
    p_afull = 5;
    run(2000);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
